// File: rtl/color_uart_tx.sv
// Colour-code UART transmitter: sends the ASCII letter of each new colour as 8N1 frames.
// Define COLOR_TX_NEWLINE_EN to append CR LF to every message (3 frames instead of 1).
module color_uart_tx #(
    parameter int CLKS_PER_BIT = 104
) (
    input  logic       clk_1MHz,
    input  logic       rst_n,
    input  logic [1:0] color,
    output logic       tx,
    output logic       busy,
    output logic       msg_done
);

    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);

`ifdef COLOR_TX_NEWLINE_EN
    localparam logic [1:0] LAST_BYTE = 2'd2;
`else
    localparam logic [1:0] LAST_BYTE = 2'd0;
`endif

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_STOP  = 3'd3;
    localparam logic [2:0] S_NEXT  = 3'd4;

    logic [2:0]    state_q, state_d;
    logic [1:0]    color_q, color_d;
    logic [1:0]    last_sent_q, last_sent_d;
    logic [1:0]    msg_code_q, msg_code_d;
    logic [1:0]    byte_idx_q, byte_idx_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [BW-1:0] baud_q, baud_d;

    logic [7:0] cur_byte;
    logic [7:0] letter;
    logic       baud_tick;

    always_comb begin
        letter = 8'h43;
        case (msg_code_q)
            2'b00: letter = 8'h43;
            2'b01: letter = 8'h52;
            2'b10: letter = 8'h47;
            2'b11: letter = 8'h42;
            default: letter = 8'h43;
        endcase
    end

    always_comb begin
        cur_byte = letter;
        case (byte_idx_q)
            2'd1:    cur_byte = 8'h0D;
            2'd2:    cur_byte = 8'h0A;
            default: cur_byte = letter;
        endcase
    end

    assign baud_tick = (baud_q == '0);

    always_comb begin
        state_d     = state_q;
        color_d     = color;
        last_sent_d = last_sent_q;
        msg_code_d  = msg_code_q;
        byte_idx_d  = byte_idx_q;
        bit_idx_d   = bit_idx_q;
        baud_d      = baud_q;
        tx          = 1'b1;
        busy        = 1'b1;
        msg_done    = 1'b0;

        case (state_q)
            S_IDLE: begin
                busy = 1'b0;
                // Only the colour seen now matters; anything that came and went is dropped.
                if (color_q != last_sent_q) begin
                    msg_code_d  = color_q;
                    last_sent_d = color_q;
                    byte_idx_d  = 2'd0;
                    bit_idx_d   = 3'd0;
                    baud_d      = BAUD_MAX;
                    state_d     = S_START;
                end
            end
            S_START: begin
                tx = 1'b0;
                if (baud_tick) begin
                    baud_d    = BAUD_MAX;
                    bit_idx_d = 3'd0;
                    state_d   = S_DATA;
                end else begin
                    baud_d = baud_q - 1'b1;
                end
            end
            S_DATA: begin
                tx = cur_byte[bit_idx_q];
                if (baud_tick) begin
                    baud_d = BAUD_MAX;
                    if (bit_idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q - 1'b1;
                end
            end
            S_STOP: begin
                if (baud_tick) begin
                    msg_done  = (byte_idx_q == LAST_BYTE);
                    baud_d    = '0;
                    bit_idx_d = 3'd0;
                    state_d   = S_NEXT;
                end else begin
                    baud_d = baud_q - 1'b1;
                end
            end
            S_NEXT: begin
                if (byte_idx_q != LAST_BYTE) begin
                    byte_idx_d = byte_idx_q + 2'd1;
                    baud_d     = BAUD_MAX;
                    state_d    = S_START;
                end else begin
                    byte_idx_d = 2'd0;
                    state_d    = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_1MHz or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            color_q     <= 2'b00;
            last_sent_q <= 2'b00;
            msg_code_q  <= 2'b00;
            byte_idx_q  <= 2'd0;
            bit_idx_q   <= 3'd0;
            baud_q      <= '0;
        end else begin
            state_q     <= state_d;
            color_q     <= color_d;
            last_sent_q <= last_sent_d;
            msg_code_q  <= msg_code_d;
            byte_idx_q  <= byte_idx_d;
            bit_idx_q   <= bit_idx_d;
            baud_q      <= baud_d;
        end
    end

endmodule

// File: tb/tb_color_uart_tx.sv
// Scoreboard bench for color_uart_tx: message-level reference model plus a UART line decoder.
// Works with or without COLOR_TX_NEWLINE_EN defined.
module tb_color_uart_tx;

    localparam int CPB = 104;
`ifdef COLOR_TX_NEWLINE_EN
    localparam int MSG_BYTES = 3;
`else
    localparam int MSG_BYTES = 1;
`endif
    localparam int MSG_CYCLES = MSG_BYTES * (10 * CPB + 1);

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] color = 2'b00;
    logic       tx;
    logic       busy;
    logic       msg_done;

    int total = 0;
    int bad   = 0;

    color_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk_1MHz (clk),
        .rst_n    (rst_n),
        .color    (color),
        .tx       (tx),
        .busy     (busy),
        .msg_done (msg_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    function automatic logic [7:0] ascii_of(input logic [1:0] c);
        case (c)
            2'b00:   return 8'h43;
            2'b01:   return 8'h52;
            2'b10:   return 8'h47;
            default: return 8'h42;
        endcase
    endfunction

    // Reference model: a message occupies a fixed number of cycles once started.
    logic [7:0] exp_q[$];
    logic [1:0] m_cq;
    logic [1:0] m_last;
    int         m_rem;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cq   = 2'b00;
            m_last = 2'b00;
            m_rem  = 0;
            exp_q.delete();
        end else begin
            if (m_rem == 0 && m_cq != m_last) begin
                exp_q.push_back(ascii_of(m_cq));
                if (MSG_BYTES == 3) begin
                    exp_q.push_back(8'h0D);
                    exp_q.push_back(8'h0A);
                end
                m_last = m_cq;
                m_rem  = MSG_CYCLES;
            end else if (m_rem > 0) begin
                m_rem--;
            end
            m_cq = color;
        end
    end

    // Per-cycle control outputs against the model.
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_tx", {31'd0, tx}, 32'd1);
            chk("rst_busy", {31'd0, busy}, 32'd0);
            chk("rst_msg_done", {31'd0, msg_done}, 32'd0);
        end else begin
            chk("busy", {31'd0, busy}, {31'd0, (m_rem > 0)});
            chk("msg_done", {31'd0, msg_done}, {31'd0, (m_rem == 2)});
            if (m_rem == 0)
                chk("idle_tx", {31'd0, tx}, 32'd1);
            if (m_rem == MSG_CYCLES)
                chk("start_latency_tx", {31'd0, tx}, 32'd0);
        end
    end

    // Line decoder / scoreboard consumer.
    bit         mon_act = 1'b0;
    int         mon_cnt = 0;
    logic [7:0] mon_byte = 8'h00;

    always @(negedge clk) begin
        if (!rst_n) begin
            mon_act = 1'b0;
        end else if (!mon_act) begin
            if (tx == 1'b0) begin
                mon_act = 1'b1;
                mon_cnt = 0;
            end
        end else begin
            mon_cnt++;
            if (mon_cnt == CPB / 2) begin
                chk("start_bit", {31'd0, tx}, 32'd0);
            end else if (mon_cnt > CPB / 2 && ((mon_cnt - CPB / 2) % CPB) == 0) begin
                int k;
                k = (mon_cnt - CPB / 2) / CPB;
                if (k <= 8) begin
                    mon_byte[k-1] = tx;
                end else begin
                    chk("stop_bit", {31'd0, tx}, 32'd1);
                    if (exp_q.size() == 0) begin
                        chk("unexpected_byte", {24'd0, mon_byte}, 32'hFFFF_FFFF);
                    end else begin
                        chk("rx_byte", {24'd0, mon_byte}, {24'd0, exp_q.pop_front()});
                    end
                    mon_act = 1'b0;
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic settle();
        int  i;
        bit  ok;
        ok = 1'b0;
        for (i = 0; i < 4 * MSG_CYCLES + 200; i++) begin
            @(negedge clk);
            if (!busy && m_rem == 0 && color == m_last && m_cq == m_last && !mon_act) begin
                ok = 1'b1;
                break;
            end
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL settle_timeout: got busy=%0b expected idle at %0t", busy, $time);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        color = 2'b00;
        cyc(5);
        rst_n = 1'b1;
        cyc(5000);

        color = 2'b01;
        settle();
        color = 2'b00;
        settle();

        // Colour changes during 'R': only the final value follows.
        color = 2'b01;
        cyc(300);
        color = 2'b11;
        cyc(200);
        color = 2'b10;
        settle();

        // During 'G', bounce through 01 and end at 00.
        color = 2'b00;
        settle();
        color = 2'b10;
        cyc(100);
        color = 2'b00;
        cyc(20);
        color = 2'b01;
        cyc(20);
        color = 2'b00;
        settle();

        // Reset in the middle of a frame.
        color = 2'b11;
        cyc(2 + 400);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_tx", {31'd0, tx}, 32'd1);
        chk("async_rst_busy", {31'd0, busy}, 32'd0);
        color = 2'b00;
        cyc(3);
        rst_n = 1'b1;
        cyc(3000);
        color = 2'b11;
        settle();

        for (int n = 0; n < 12; n++) begin
            color = 2'($urandom_range(0, 3));
            cyc($urandom_range(1, 1500));
        end
        settle();
        cyc(10);

        chk("queue_empty", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
